// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole datapath: hole geometry, the
// "no mole" marker, the spawner state type and the LFSR step function.
package mole_pkg;

    localparam int              NUM_HOLES = 18;
    localparam int              POS_W     = 5;
    localparam logic [POS_W-1:0] NO_MOLE  = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP,
        DONE
    } mole_state_t;

    // 16-bit Galois LFSR, taps 0xB400 (maximal length).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used as the hole-selection entropy source.
// Advances every cycle; asynchronous reset returns it to SEED (must be non-zero).
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: tick prescaler, IDLE/GAP/UP/DONE round FSM, hole selection and
// miss counting. Define MOLE_SPEEDUP_EN to shorten the visible time on each hit.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int          TICK_DIV     = 50000,
    parameter int          GAP_TICKS    = 500,
    parameter int          UP_TICKS     = 1500,
    parameter int          MIN_UP_TICKS = 300,
    parameter int          STEP_TICKS   = 100,
    parameter int          MAX_MISSES   = 5,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hit,
    output logic [POS_W-1:0] mole_position,
    output logic             mole_active,
    output logic [3:0]       miss_count,
    output logic             game_over
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [15:0]        lfsr_state;
    logic               unused_lfsr;
    mole_state_t        state;
    logic [15:0]        timer;
    logic [15:0]        up_ticks;
    logic [POS_W-1:0]   prev_pos;
    logic [POS_W-1:0]   next_hole;
    logic [3:0]         miss_inc;
    logic               gap_last;
    logic               up_last;

    // ------------------------------------------------------------------
    // Entropy source
    // ------------------------------------------------------------------
    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state[15:5];

    // ------------------------------------------------------------------
    // Tick prescaler: free-running, tick on the last count of each period
    // ------------------------------------------------------------------
    assign tick = (presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hole selection: fold 0..31 onto 0..17 and never repeat the last hole
    // ------------------------------------------------------------------
    function automatic logic [POS_W-1:0] pick_hole(input logic [4:0]       raw,
                                                   input logic [POS_W-1:0] prev);
        logic [POS_W-1:0] c;
        c = (raw >= 5'(NUM_HOLES)) ? raw - 5'(NUM_HOLES) : raw;
        if (c == prev) begin
            c = (c == 5'(NUM_HOLES - 1)) ? '0 : c + 5'd1;
        end
        return c;
    endfunction

    assign next_hole = pick_hole(lfsr_state[4:0], prev_pos);
    assign miss_inc  = miss_count + 4'd1;
    assign gap_last  = tick && (timer == 16'(GAP_TICKS - 1));
    assign up_last   = tick && (timer == up_ticks - 16'd1);

    // ------------------------------------------------------------------
    // Visible-time control
    // ------------------------------------------------------------------
`ifdef MOLE_SPEEDUP_EN
    logic [16:0] speedup_floor;
    logic [15:0] sped_up_ticks;

    // 17-bit compare keeps the subtraction from ever wrapping below the floor.
    assign speedup_floor = 17'(MIN_UP_TICKS) + 17'(STEP_TICKS);
    assign sped_up_ticks = ({1'b0, up_ticks} >= speedup_floor)
                         ? up_ticks - 16'(STEP_TICKS)
                         : 16'(MIN_UP_TICKS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_ticks <= 16'(UP_TICKS);
        end else if ((state == IDLE || state == DONE) && start) begin
            up_ticks <= 16'(UP_TICKS);
        end else if (state == UP && hit) begin
            up_ticks <= sped_up_ticks;
        end
    end
`else
    localparam int unused_speedup_cfg = STEP_TICKS + MIN_UP_TICKS;

    assign up_ticks = 16'(UP_TICKS);
`endif

    // ------------------------------------------------------------------
    // Round FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            prev_pos      <= '0;
            mole_position <= NO_MOLE;
            mole_active   <= 1'b0;
            miss_count    <= '0;
            game_over     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= GAP;
                        timer      <= '0;
                        miss_count <= '0;
                        game_over  <= 1'b0;
                    end
                end

                GAP: begin
                    if (gap_last) begin
                        state         <= UP;
                        timer         <= '0;
                        mole_position <= next_hole;
                        prev_pos      <= next_hole;
                        mole_active   <= 1'b1;
                    end else if (tick) begin
                        timer <= timer + 16'd1;
                    end
                end

                UP: begin
                    // A hit wins over a coincident timeout.
                    if (hit) begin
                        state         <= GAP;
                        timer         <= '0;
                        mole_position <= NO_MOLE;
                        mole_active   <= 1'b0;
                    end else if (up_last) begin
                        timer         <= '0;
                        mole_position <= NO_MOLE;
                        mole_active   <= 1'b0;
                        miss_count    <= miss_inc;
                        if (miss_inc == 4'(MAX_MISSES)) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else if (tick) begin
                        timer <= timer + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: directed round scenarios plus a
// randomised spawn run, all compared against a phase/countdown reference model.
module tb_mole_spawner;

    localparam int          GAP_T  = 4;
    localparam int          UP_T   = 10;
    localparam int          MIN_T  = 4;
    localparam int          STEP_T = 3;
    localparam int          MAX_M  = 3;
    localparam logic [15:0] SEED   = 16'hACE1;
`ifdef MOLE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       hit;
    logic [4:0] mole_position;
    logic       mole_active;
    logic [3:0] miss_count;
    logic       game_over;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    mole_spawner #(
        .TICK_DIV     (1),
        .GAP_TICKS    (GAP_T),
        .UP_TICKS     (UP_T),
        .MIN_UP_TICKS (MIN_T),
        .STEP_TICKS   (STEP_T),
        .MAX_MISSES   (MAX_M),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .hit           (hit),
        .mole_position (mole_position),
        .mole_active   (mole_active),
        .miss_count    (miss_count),
        .game_over     (game_over)
    );

    initial forever #5 clk = ~clk;

    // Reference model: round phase plus a countdown of cycles left in it.
    typedef enum int {PH_IDLE, PH_GAP, PH_UP, PH_DONE} phase_t;

    phase_t      ph;
    int          remaining;
    int          up_len;
    int          m_miss;
    int          m_pos;
    int          prev_shown;
    bit          m_over;
    logic [15:0] lfsr_m;

    task automatic model_reset();
        ph         = PH_IDLE;
        remaining  = 0;
        up_len     = UP_T;
        m_miss     = 0;
        m_pos      = 31;
        prev_shown = 0;
        m_over     = 1'b0;
        lfsr_m     = SEED;
    endtask

    task automatic model_edge(input bit s, input bit h);
        int c;
        c = int'(lfsr_m[4:0]) % 32;
        if (c >= 18) c = c - 18;
        if (c == prev_shown) c = (c + 1) % 18;
        lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
        case (ph)
            PH_IDLE, PH_DONE: begin
                if (s) begin
                    ph        = PH_GAP;
                    remaining = GAP_T;
                    m_miss    = 0;
                    m_over    = 1'b0;
                    up_len    = UP_T;
                end
            end
            PH_GAP: begin
                remaining--;
                if (remaining == 0) begin
                    ph         = PH_UP;
                    remaining  = up_len;
                    m_pos      = c;
                    prev_shown = c;
                end
            end
            PH_UP: begin
                if (h) begin
                    ph        = PH_GAP;
                    remaining = GAP_T;
                    if (SPEEDUP) up_len = (up_len - STEP_T < MIN_T) ? MIN_T : up_len - STEP_T;
                end else begin
                    remaining--;
                    if (remaining == 0) begin
                        m_miss++;
                        if (m_miss == MAX_M) begin
                            ph     = PH_DONE;
                            m_over = 1'b1;
                        end else begin
                            ph        = PH_GAP;
                            remaining = GAP_T;
                        end
                    end
                end
            end
            default: ph = PH_IDLE;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/pos"},    32'(mole_position), (ph == PH_UP) ? m_pos : 31);
        check({tag, "/active"}, 32'(mole_active),   (ph == PH_UP) ? 1 : 0);
        check({tag, "/miss"},   32'(miss_count),    m_miss);
        check({tag, "/over"},   32'(game_over),     32'(m_over));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "/pos"},    32'(mole_position), 31);
        check({tag, "/active"}, 32'(mole_active),   0);
        check({tag, "/miss"},   32'(miss_count),    0);
        check({tag, "/over"},   32'(game_over),     0);
    endtask

    // One clock: drive inputs, advance DUT and model together, compare at +1.
    task automatic cycle(input bit s, input bit h, input string tag);
        start = s;
        hit   = h;
        @(posedge clk);
        model_edge(s, h);
        #1;
        start = 1'b0;
        hit   = 1'b0;
        check_outputs(tag);
    endtask

    task automatic wait_active(input string tag, output int waited);
        waited = 0;
        while (!mole_active && waited < 100) begin
            cycle(1'b0, 1'b0, tag);
            waited++;
        end
        check({tag, "/appeared"}, 32'(mole_active), 1);
    endtask

    // Length of one UP window; optionally hits on its final cycle.
    task automatic measure_window(input string tag, input bit hit_last, output int len);
        int waited;
        int guard;
        wait_active(tag, waited);
        len   = 0;
        guard = 0;
        while (mole_active && guard < 50) begin
            cycle(1'b0, hit_last && ph == PH_UP && remaining == 1, tag);
            len++;
            guard++;
        end
    endtask

    initial begin
        int win;
        int waited;
        int spawns;
        int last_pos;
        int guard;
        bit was_active;

        reset = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        model_reset();
        #1;
        check_reset_values("reset");
        #20;
        reset = 1'b0;

        // Idle: no start for 20 cycles.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, "idle");

        // First round, no hits: a 10-cycle window then one miss.
        cycle(1'b1, 1'b0, "start");
        win = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b0, "first_up");
            if (mole_active) begin
                win++;
                check("first_up/range", 32'(mole_position <= 5'd17), 1);
            end
        end
        check("first_window_len", win, UP_T);
        check("first_miss", 32'(miss_count), 1);
        check("first_pos_cleared", 32'(mole_position), 31);

        // Hit on the third UP cycle.
        wait_active("hit3_wait", waited);
        cycle(1'b0, 1'b0, "hit3_up1");
        cycle(1'b0, 1'b0, "hit3_up2");
        cycle(1'b0, 1'b1, "hit3");
        check("hit3_drop", 32'(mole_active), 0);
        check("hit3_pos", 32'(mole_position), 31);
        check("hit3_miss_kept", 32'(miss_count), 1);

        // Windows after speedup; hits land on the final (timeout) cycle.
        measure_window("win2", 1'b1, win);
        check("win2_len", win, SPEEDUP ? 7 : 10);
        check("win2_hit_on_timeout_miss", 32'(miss_count), 1);
        measure_window("win3", 1'b1, win);
        check("win3_len", win, SPEEDUP ? 4 : 10);
        measure_window("win4", 1'b0, win);
        check("win4_floor_len", win, SPEEDUP ? 4 : 10);
        check("win4_miss", 32'(miss_count), 2);
        measure_window("win5", 1'b0, win);
        check("game_over", 32'(game_over), 1);
        check("game_over_miss", 32'(miss_count), MAX_M);

        // DONE holds; hits are ignored.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, "done_hold");
            check("done_hold/pos", 32'(mole_position), 31);
        end

        // Restart: flags clear on the start edge, mole four cycles later.
        cycle(1'b1, 1'b0, "restart");
        check("restart_over", 32'(game_over), 0);
        check("restart_miss", 32'(miss_count), 0);
        wait_active("restart_wait", waited);
        check("restart_delay", waited, GAP_T);
        measure_window("reload", 1'b0, win);
        check("reload_window_len", win, UP_T);

        // Randomised run: 200 spawns, random hits/starts.
        spawns   = 0;
        last_pos = -1;
        guard    = 0;
        while (spawns < 200 && guard < 20000) begin
            was_active = mole_active;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, "rand");
            if (mole_active && !was_active) begin
                spawns++;
                check("rand/range", 32'(mole_position <= 5'd17), 1);
                if (last_pos >= 0) check("rand/no_repeat", 32'(int'(mole_position) != last_pos), 1);
                last_pos = int'(mole_position);
            end
            guard++;
        end
        check("rand/spawn_count", spawns, 200);

        // Asynchronous reset in the middle of an UP window.
        if (!mole_active) cycle(1'b1, 1'b0, "pre_reset_start");
        wait_active("pre_reset", waited);
        cycle(1'b0, 1'b0, "pre_reset_up");
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("reset_held");
        #3;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, "post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
